bram_loader: RTL

Byte-stream writer that fills the shared 8-bit bias/weights BRAM before inference. It accepts bytes from a host-side link over a valid/ready handshake and writes them to consecutive addresses from a programmable base. It pulses a finish flag when the block is loaded. It drives the write side of the same BRAM port that the conv/fc layer engines later read through `bias_weights_bram_ena` / `bias_weights_bram_addra`.

---
 rtl/bram_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bram_loader.sv
// bram_loader: byte-stream writer that fills the shared bias/weights BRAM.
// Bytes arrive over a valid/ready handshake and are written to consecutive
// addresses starting at a programmable base. A one-cycle finish pulse marks
// completion.
// Optional feature macro: BRAM_LOADER_CHECKSUM_EN -- adds a trailer byte
// holding the mod-256 sum of the data bytes and reports a mismatch on
// load_error. When the macro is undefined, load_error is tied to 0.
module bram_loader #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  s_valid,
    input  logic [DATA_SIZE-1:0]  s_data,
    output logic                  s_ready,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_SIZE-1:0]  bram_dina,
    output logic                  load_busy,
    output logic                  load_finish,
    output logic                  load_error
);

`ifdef BRAM_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_WRITE = 4'b0010,
        S_CHECK = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_WRITE = 3'b010,
        S_DONE  = 3'b100
    } state_t;
`endif

    state_t                state;
    state_t                state_next;
    logic                  load_en_q;
    logic                  start;
    logic                  beat;
    logic                  last_beat;
    logic                  ready_next;
    logic                  busy_next;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] count;
    logic [DATA_SIZE-1:0]  checksum;

    assign start     = load_en & ~load_en_q;
    assign beat      = s_valid & s_ready;
    assign last_beat = beat && (count == len_q - ADDR_WIDTH'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; ready/busy are derived from the next state so the
    // registered copies line up with the state they describe.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = (load_len == '0) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
`ifdef BRAM_LOADER_CHECKSUM_EN
                if (last_beat) state_next = S_CHECK;
`else
                if (last_beat) state_next = S_DONE;
`endif
            end
`ifdef BRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (beat) state_next = S_DONE;
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
`ifdef BRAM_LOADER_CHECKSUM_EN
        ready_next = (state_next == S_WRITE) || (state_next == S_CHECK);
`else
        ready_next = (state_next == S_WRITE);
`endif
        busy_next = ready_next;
    end

    // Rising-edge detector for the start request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) load_en_q <= 1'b0;
        else     load_en_q <= load_en;
    end

    // Datapath: parameter capture, write strobes, counter, checksum, flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            count       <= '0;
            checksum    <= '0;
            s_ready     <= 1'b0;
            load_busy   <= 1'b0;
            load_finish <= 1'b0;
            bram_ena    <= 1'b0;
            bram_wea    <= 1'b0;
            bram_addra  <= '0;
            bram_dina   <= '0;
        end else begin
            s_ready     <= ready_next;
            load_busy   <= busy_next;
            load_finish <= (state == S_DONE);
            bram_ena    <= 1'b0;
            bram_wea    <= 1'b0;
            if (state == S_IDLE && start) begin
                base_q   <= load_base;
                len_q    <= load_len;
                count    <= '0;
                checksum <= '0;
            end
            if (state == S_WRITE && beat) begin
                bram_ena   <= 1'b1;
                bram_wea   <= 1'b1;
                bram_addra <= base_q + count;
                bram_dina  <= s_data;
                count      <= count + ADDR_WIDTH'(1);
                checksum   <= checksum + s_data;
            end
        end
    end

`ifdef BRAM_LOADER_CHECKSUM_EN
    // Trailer comparison; the flag holds until the next start clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_error <= 1'b0;
        end else if (state == S_IDLE && start) begin
            load_error <= 1'b0;
        end else if (state == S_CHECK && beat) begin
            load_error <= (s_data != checksum);
        end
    end
`else
    assign load_error = 1'b0;
`endif

endmodule
